control_unit_pipelined: RTL and testbench

//  Next-generation RV32I control unit for the 5-stage core: decodes Op/funct3/funct7 in D and

---
 rtl/control_unit_pipelined.sv | 226 ++++++++++++++++++++++
 tb/tb_control_unit_pipelined.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_pipelined.sv
// RV32I control unit: decodes the D-stage instruction and carries its control
// bits through the E, M and W pipeline registers, with stall/flush bubbles.
module control_unit_pipelined #(
    parameter int ALUCTRL_W = 4,
    parameter bit ENABLE_M  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid_d,
    input  logic [6:0]           op_d,
    input  logic [2:0]           funct3_d,
    input  logic [6:0]           funct7_d,
    input  logic                 stall_d,
    input  logic                 flush_e,
    input  logic                 zero_e,
    output logic [2:0]           imm_src_d,
    output logic                 illegal_d,
    output logic [ALUCTRL_W-1:0] alu_control_e,
    output logic                 alu_src_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic                 pc_src_e,
    output logic                 reg_write_m,
    output logic                 mem_write_m,
    output logic [1:0]           result_src_m,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic                 illegal_sticky
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_t;

    // An all-zero bundle is the bubble: no writes, no control flow, ADD, ALU result.
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 alu_src;
        logic                 branch;
        logic                 jump;
        logic                 jalr;
        logic [1:0]           result_src;
        logic [ALUCTRL_W-1:0] alu_control;
    } ctrl_t;

    function automatic alu_op_t alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

    function automatic logic [ALUCTRL_W-1:0] widen(input alu_op_t a);
        widen      = '0;
        widen[3:0] = a;
    endfunction

    ctrl_t   dec;
    ctrl_t   ctrl_e;
    alu_op_t alu_op;
    logic    bad;
    logic    funct3_e0;

    always_comb begin
        dec       = '0;
        alu_op    = ALU_ADD;
        bad       = 1'b0;
        imm_src_d = IMM_I;
        case (op_d)
            OP_R: begin
                dec.reg_write = 1'b1;
                if (funct7_d == F7_BASE) begin
                    alu_op = alu_base(funct3_d);
                end else if (funct7_d == F7_ALT) begin
                    if (funct3_d == 3'b000)      alu_op = ALU_SUB;
                    else if (funct3_d == 3'b101) alu_op = ALU_SRA;
                    else                         bad    = 1'b1;
                end else if (funct7_d == F7_MUL && ENABLE_M && funct3_d == 3'b000) begin
                    alu_op = ALU_MUL;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_I_ALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                // funct7 is immediate data except for the shift-immediate forms.
                if (funct3_d == 3'b001) begin
                    if (funct7_d == F7_BASE) alu_op = ALU_SLL;
                    else                     bad    = 1'b1;
                end else if (funct3_d == 3'b101) begin
                    if (funct7_d == F7_BASE)     alu_op = ALU_SRL;
                    else if (funct7_d == F7_ALT) alu_op = ALU_SRA;
                    else                         bad    = 1'b1;
                end else begin
                    alu_op = alu_base(funct3_d);
                end
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src_d     = IMM_S;
            end
            OP_BRANCH: begin
                imm_src_d  = IMM_B;
                dec.branch = 1'b1;
                alu_op     = ALU_SUB;
                bad        = (funct3_d[2:1] != 2'b00);
            end
            OP_JAL: begin
                imm_src_d      = IMM_J;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_JALR: begin
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
                bad            = (funct3_d != 3'b000);
            end
            OP_LUI: begin
                imm_src_d      = IMM_U;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_IMM;
            end
            default: bad = 1'b1;
        endcase
        dec.alu_control = widen(alu_op);
        illegal_d       = instr_valid_d & bad;
    end

    // Any reason not to issue (reset, squash, hold, no/illegal instruction) injects a bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_e || stall_d || !instr_valid_d || illegal_d) begin
            ctrl_e    <= '0;
            funct3_e0 <= 1'b0;
        end else begin
            ctrl_e    <= dec;
            funct3_e0 <= funct3_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            reg_write_w  <= 1'b0;
            result_src_w <= RES_ALU;
        end else begin
            reg_write_m  <= ctrl_e.reg_write;
            mem_write_m  <= ctrl_e.mem_write;
            result_src_m <= ctrl_e.result_src;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
        end
    end

    // Only an illegal instruction that would really have issued is recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_sticky <= 1'b0;
        end else if (instr_valid_d && illegal_d && !stall_d && !flush_e) begin
            illegal_sticky <= 1'b1;
        end
    end

    assign alu_control_e = ctrl_e.alu_control;
    assign alu_src_e     = ctrl_e.alu_src;
    assign branch_e      = ctrl_e.branch;
    assign jump_e        = ctrl_e.jump;
    assign jalr_e        = ctrl_e.jalr;
    // funct3[0] distinguishes BEQ (taken on zero) from BNE (taken on nonzero).
    assign pc_src_e      = ctrl_e.jump | (ctrl_e.branch & (zero_e ^ funct3_e0));

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Directed, table-driven bench for control_unit_pipelined with ENABLE_M=0 and
// ENABLE_M=1 instances sharing the same D-stage stimulus.
module tb_control_unit_pipelined;

    logic       clk;
    logic       rst;
    logic       instr_valid_d;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic [6:0] funct7_d;
    logic       stall_d;
    logic       flush_e;
    logic       zero_e;

    logic [2:0] imm_src_d;
    logic       illegal_d;
    logic [3:0] alu_control_e;
    logic       alu_src_e, branch_e, jump_e, jalr_e, pc_src_e;
    logic       reg_write_m, mem_write_m;
    logic [1:0] result_src_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic       illegal_sticky;

    logic [2:0] m1_imm_src_d;
    logic       m1_illegal_d;
    logic [3:0] m1_alu_control_e;
    logic       m1_alu_src_e, m1_branch_e, m1_jump_e, m1_jalr_e, m1_pc_src_e;
    logic       m1_reg_write_m, m1_mem_write_m;
    logic [1:0] m1_result_src_m;
    logic       m1_reg_write_w;
    logic [1:0] m1_result_src_w;
    logic       m1_illegal_sticky;

    int n_cmp  = 0;
    int n_fail = 0;

    control_unit_pipelined #(.ALUCTRL_W(4), .ENABLE_M(1'b0)) dut (
        .clk(clk), .rst(rst), .instr_valid_d(instr_valid_d), .op_d(op_d),
        .funct3_d(funct3_d), .funct7_d(funct7_d), .stall_d(stall_d), .flush_e(flush_e),
        .zero_e(zero_e), .imm_src_d(imm_src_d), .illegal_d(illegal_d),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .branch_e(branch_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .pc_src_e(pc_src_e),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w),
        .illegal_sticky(illegal_sticky)
    );

    control_unit_pipelined #(.ALUCTRL_W(4), .ENABLE_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .instr_valid_d(instr_valid_d), .op_d(op_d),
        .funct3_d(funct3_d), .funct7_d(funct7_d), .stall_d(stall_d), .flush_e(flush_e),
        .zero_e(zero_e), .imm_src_d(m1_imm_src_d), .illegal_d(m1_illegal_d),
        .alu_control_e(m1_alu_control_e), .alu_src_e(m1_alu_src_e), .branch_e(m1_branch_e),
        .jump_e(m1_jump_e), .jalr_e(m1_jalr_e), .pc_src_e(m1_pc_src_e),
        .reg_write_m(m1_reg_write_m), .mem_write_m(m1_mem_write_m),
        .result_src_m(m1_result_src_m), .reg_write_w(m1_reg_write_w),
        .result_src_w(m1_result_src_w), .illegal_sticky(m1_illegal_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       asrc;
        logic       br;
        logic       jmp;
        logic       jalr;
        logic       pc;
        logic       rw;
        logic       mw;
        logic [1:0] res;
    } vec_t;

    vec_t tbl[$];

    task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic st, input logic fl);
        instr_valid_d = v;
        op_d          = op;
        funct3_d      = f3;
        funct7_d      = f7;
        stall_d       = st;
        flush_e       = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] pipe_state();
        pipe_state = {15'd0, alu_control_e, alu_src_e, branch_e, jump_e, jalr_e, pc_src_e,
                      reg_write_m, mem_write_m, result_src_m, reg_write_w, result_src_w,
                      illegal_sticky};
    endfunction

    task automatic idle();
        applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // name, op, f3, f7, ill, imm, alu, asrc, br, jmp, jalr, pc, rw, mw, res
        tbl.push_back('{"add",      7'b0110011, 3'b000, 7'b0000000, 0, 3'b000, 4'd0, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"sub",      7'b0110011, 3'b000, 7'b0100000, 0, 3'b000, 4'd1, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"sll",      7'b0110011, 3'b001, 7'b0000000, 0, 3'b000, 4'd7, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"slt",      7'b0110011, 3'b010, 7'b0000000, 0, 3'b000, 4'd5, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"sltu",     7'b0110011, 3'b011, 7'b0000000, 0, 3'b000, 4'd6, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"xor",      7'b0110011, 3'b100, 7'b0000000, 0, 3'b000, 4'd4, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"srl",      7'b0110011, 3'b101, 7'b0000000, 0, 3'b000, 4'd8, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"sra",      7'b0110011, 3'b101, 7'b0100000, 0, 3'b000, 4'd9, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"or",       7'b0110011, 3'b110, 7'b0000000, 0, 3'b000, 4'd3, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"and",      7'b0110011, 3'b111, 7'b0000000, 0, 3'b000, 4'd2, 0,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"addi",     7'b0010011, 3'b000, 7'b0100000, 0, 3'b000, 4'd0, 1,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"srai",     7'b0010011, 3'b101, 7'b0100000, 0, 3'b000, 4'd9, 1,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"andi",     7'b0010011, 3'b111, 7'b1111111, 0, 3'b000, 4'd2, 1,0,0,0,0, 1,0, 2'b00});
        tbl.push_back('{"slli_bad", 7'b0010011, 3'b001, 7'b0100000, 1, 3'b000, 4'd0, 0,0,0,0,0, 0,0, 2'b00});
        tbl.push_back('{"lw",       7'b0000011, 3'b010, 7'b0000000, 0, 3'b000, 4'd0, 1,0,0,0,0, 1,0, 2'b01});
        tbl.push_back('{"sw",       7'b0100011, 3'b010, 7'b0000000, 0, 3'b001, 4'd0, 1,0,0,0,0, 0,1, 2'b00});
        tbl.push_back('{"beq",      7'b1100011, 3'b000, 7'b0000000, 0, 3'b010, 4'd1, 0,1,0,0,0, 0,0, 2'b00});
        tbl.push_back('{"bne",      7'b1100011, 3'b001, 7'b0000000, 0, 3'b010, 4'd1, 0,1,0,0,1, 0,0, 2'b00});
        tbl.push_back('{"blt_bad",  7'b1100011, 3'b100, 7'b0000000, 1, 3'b010, 4'd0, 0,0,0,0,0, 0,0, 2'b00});
        tbl.push_back('{"jal",      7'b1101111, 3'b000, 7'b0110101, 0, 3'b011, 4'd0, 0,0,1,0,1, 1,0, 2'b10});
        tbl.push_back('{"jalr",     7'b1100111, 3'b000, 7'b0000000, 0, 3'b000, 4'd0, 1,0,1,1,1, 1,0, 2'b10});
        tbl.push_back('{"jalr_bad", 7'b1100111, 3'b010, 7'b0000000, 1, 3'b000, 4'd0, 0,0,0,0,0, 0,0, 2'b00});
        tbl.push_back('{"lui",      7'b0110111, 3'b011, 7'b1010101, 0, 3'b100, 4'd0, 0,0,0,0,0, 1,0, 2'b11});
        tbl.push_back('{"undef",    7'b1111111, 3'b000, 7'b0000000, 1, 3'b000, 4'd0, 0,0,0,0,0, 0,0, 2'b00});
        tbl.push_back('{"r_f7bad",  7'b0110011, 3'b000, 7'b0000010, 1, 3'b000, 4'd0, 0,0,0,0,0, 0,0, 2'b00});
        tbl.push_back('{"r_shbad",  7'b0110011, 3'b001, 7'b0100000, 1, 3'b000, 4'd0, 0,0,0,0,0, 0,0, 2'b00});

        // Reset with a JAL sitting in D: everything downstream must stay quiet.
        zero_e = 1'b0;
        rst    = 1'b1;
        applyStimulus(1'b1, 7'b1101111, 3'd0, 7'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", pipe_state(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        foreach (tbl[i]) begin
            @(negedge clk);
            applyStimulus(1'b1, tbl[i].op, tbl[i].f3, tbl[i].f7, 1'b0, 1'b0);
            #1;
            checkOutput({tbl[i].name, "_illegal_d"}, 32'(illegal_d), 32'(tbl[i].ill));
            checkOutput({tbl[i].name, "_imm_src_d"}, 32'(imm_src_d), 32'(tbl[i].imm));
            @(posedge clk);
            #1;
            idle();
            checkOutput({tbl[i].name, "_alu_e"},    32'(alu_control_e), 32'(tbl[i].alu));
            checkOutput({tbl[i].name, "_flow_e"},
                        32'({alu_src_e, branch_e, jump_e, jalr_e, pc_src_e}),
                        32'({tbl[i].asrc, tbl[i].br, tbl[i].jmp, tbl[i].jalr, tbl[i].pc}));
            @(posedge clk);
            #1;
            checkOutput({tbl[i].name, "_ctl_m"},
                        32'({reg_write_m, mem_write_m, result_src_m}),
                        32'({tbl[i].rw, tbl[i].mw, tbl[i].res}));
            @(posedge clk);
            #1;
            checkOutput({tbl[i].name, "_ctl_w"},
                        32'({reg_write_w, result_src_w}),
                        32'({tbl[i].rw, tbl[i].res}));
        end
        checkOutput("sticky_after_table", 32'(illegal_sticky), 32'd1);

        // Reset mid-pipeline: JAL in M, LUI in E, JAL in D, all discarded in one edge.
        @(negedge clk);
        applyStimulus(1'b1, 7'b1101111, 3'd0, 7'd0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 7'b0110111, 3'd0, 7'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 7'b1101111, 3'd0, 7'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midpipe_reset", pipe_state(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Illegal instruction only sticks when it actually issues.
        @(negedge clk);
        applyStimulus(1'b0, 7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0);
        #1;
        checkOutput("illegal_when_invalid", 32'(illegal_d), 32'd0);
        applyStimulus(1'b1, 7'b1111111, 3'd0, 7'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("sticky_under_stall", 32'(illegal_sticky), 32'd0);
        applyStimulus(1'b1, 7'b1111111, 3'd0, 7'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("sticky_under_flush", 32'(illegal_sticky), 32'd0);
        applyStimulus(1'b1, 7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        checkOutput("sticky_set", 32'(illegal_sticky), 32'd1);
        checkOutput("illegal_bubble_e", 32'({alu_control_e, alu_src_e, branch_e, jump_e, jalr_e}), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sticky_held", 32'(illegal_sticky), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("sticky_cleared", 32'(illegal_sticky), 32'd0);

        // BNE / BEQ resolution against zero_e.
        @(negedge clk);
        applyStimulus(1'b1, 7'b1100011, 3'b001, 7'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        zero_e = 1'b0;
        #1;
        checkOutput("bne_taken", 32'(pc_src_e), 32'd1);
        zero_e = 1'b1;
        #1;
        checkOutput("bne_not_taken", 32'(pc_src_e), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 7'b1100011, 3'b000, 7'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        zero_e = 1'b1;
        #1;
        checkOutput("beq_taken", 32'(pc_src_e), 32'd1);
        zero_e = 1'b0;
        #1;
        checkOutput("beq_not_taken", 32'(pc_src_e), 32'd0);

        // JALR held one cycle by the hazard unit.
        @(negedge clk);
        applyStimulus(1'b1, 7'b1100111, 3'b000, 7'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("jalr_stall_bubble", 32'({jump_e, jalr_e, alu_src_e}), 32'd0);
        stall_d = 1'b0;
        @(posedge clk);
        #1;
        idle();
        checkOutput("jalr_issued_e", 32'({jump_e, jalr_e, pc_src_e}), 32'b111);
        checkOutput("jalr_bubble_m", 32'(reg_write_m), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("jalr_m", 32'({reg_write_m, result_src_m}), 32'b110);

        // Flushed LUI must never write back.
        @(negedge clk);
        applyStimulus(1'b1, 7'b0110111, 3'd0, 7'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        idle();
        checkOutput("flush_lui_e", 32'(alu_src_e), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("flush_lui_w", 32'({reg_write_w, result_src_w}), 32'd0);

        // Stall and flush together: still a bubble.
        @(negedge clk);
        applyStimulus(1'b1, 7'b1101111, 3'd0, 7'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        idle();
        checkOutput("stall_flush_e", 32'({jump_e, pc_src_e}), 32'd0);

        // MUL: illegal without the M extension, ALU code 10 with it.
        @(negedge clk);
        applyStimulus(1'b1, 7'b0110011, 3'b000, 7'b0000001, 1'b0, 1'b0);
        #1;
        checkOutput("mul_illegal_m0", 32'(illegal_d), 32'd1);
        checkOutput("mul_legal_m1", 32'(m1_illegal_d), 32'd0);
        @(posedge clk);
        #1;
        idle();
        checkOutput("mul_alu_m1", 32'(m1_alu_control_e), 32'd10);
        checkOutput("mul_alu_m0", 32'(alu_control_e), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mul_rw_m1", 32'(m1_reg_write_m), 32'd1);
        checkOutput("mul_rw_m0", 32'(reg_write_m), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
